// File: rtl/pc_fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pc_fetch_ctrl
//  Description : Program-counter / instruction-fetch sequencer. Issues fetch
//                requests (req/ack) at the current PC, presents fetched words
//                to the decoder (valid/ready), and arbitrates PC updates between
//                sequential increment, branch redirect and interrupt entry.
//  Ports       : clk, rst          - clock, async active-high reset
//                pc_val            - current PC register value
//                pc_inc/pc_ie/pc_in- PC increment strobe, load strobe, load value
//                mem_req/mem_addr  - fetch request and address
//                mem_ack/mem_data  - fetch completion and instruction word
//                instr/instr_valid/instr_ready/stall - decoder handshake
//                br_take/br_target - branch redirect request
//                irq/irq_en/irq_ack/epc - interrupt entry and saved return PC
//  Revision    : 1.0 - initial release
// ============================================================================
module pc_fetch_ctrl #(
  parameter int              ADDR_W    = 16,
  parameter logic [ADDR_W-1:0] IRQ_VEC = 16'h0010,
  parameter int              INIT_HOLD = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_val,
  output logic              pc_inc,
  output logic              pc_ie,
  output logic [ADDR_W-1:0] pc_in,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [15:0]       mem_data,
  output logic [15:0]       instr,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              stall,
  input  logic              br_take,
  input  logic [ADDR_W-1:0] br_target,
  input  logic              irq,
  input  logic              irq_en,
  output logic              irq_ack,
  output logic [ADDR_W-1:0] epc
);

  localparam int c_hold_w = (INIT_HOLD > 1) ? $clog2(INIT_HOLD + 1) : 1;
  localparam logic [c_hold_w-1:0] c_hold_init = c_hold_w'(INIT_HOLD);
  localparam logic [c_hold_w-1:0] c_hold_one  = c_hold_w'(1);

  typedef enum logic [1:0] {
    S_HOLD  = 2'd0,
    S_FETCH = 2'd1,
    S_ISSUE = 2'd2,
    S_REDIR = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [c_hold_w-1:0] r_hold_cnt;
  logic                r_br_pend;
  logic [ADDR_W-1:0]   r_br_addr;
  logic [ADDR_W-1:0]   r_redir_addr;
  logic [15:0]         r_instr;
  logic [ADDR_W-1:0]   r_epc;

  logic                w_capture;
  logic                w_redir_load;
  logic [ADDR_W-1:0]   w_redir_val;
  logic                w_epc_load;
  logic                w_xfer;

  assign instr = r_instr;
  assign epc   = r_epc;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_HOLD;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and strobe decode
  always_comb begin
    w_state_nxt  = r_state;
    pc_inc       = 1'b0;
    pc_ie        = 1'b0;
    pc_in        = '0;
    mem_req      = 1'b0;
    mem_addr     = '0;
    instr_valid  = 1'b0;
    irq_ack      = 1'b0;
    w_capture    = 1'b0;
    w_redir_load = 1'b0;
    w_redir_val  = '0;
    w_epc_load   = 1'b0;
    w_xfer       = 1'b0;
    case (r_state)
      S_HOLD: begin
        // A count of 0 or 1 means this is the last hold cycle.
        if (r_hold_cnt <= c_hold_one) begin
          w_state_nxt = S_FETCH;
        end
      end
      S_FETCH: begin
        mem_req  = 1'b1;
        mem_addr = pc_val;
        if (mem_ack) begin
          // A branch arriving with the ack counts as pending: the word is
          // dropped and the PC is not advanced.
          if (r_br_pend || br_take) begin
            w_redir_load = 1'b1;
            w_redir_val  = br_take ? br_target : r_br_addr;
            w_state_nxt  = S_REDIR;
          end else begin
            pc_inc      = 1'b1;
            w_capture   = 1'b1;
            w_state_nxt = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        instr_valid = 1'b1;
        w_xfer      = instr_ready & ~stall;
        if (br_take) begin
          w_redir_load = 1'b1;
          w_redir_val  = br_target;
          w_state_nxt  = S_REDIR;
        end else if (w_xfer) begin
          if (irq && irq_en) begin
            // pc_val already points past the transferred instruction.
            irq_ack      = 1'b1;
            w_epc_load   = 1'b1;
            w_redir_load = 1'b1;
            w_redir_val  = IRQ_VEC;
            w_state_nxt  = S_REDIR;
          end else begin
            w_state_nxt = S_FETCH;
          end
        end
      end
      S_REDIR: begin
        pc_ie       = 1'b1;
        pc_in       = r_redir_addr;
        w_state_nxt = S_FETCH;
      end
      default: begin
        w_state_nxt = S_HOLD;
      end
    endcase
  end

  // Hold counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hold_cnt <= c_hold_init;
    end else if (r_state == S_HOLD && r_hold_cnt != '0) begin
      r_hold_cnt <= r_hold_cnt - c_hold_one;
    end
  end

  // Pending branch: captured while fetching; in REDIR it only survives if a
  // new branch arrives during that cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_br_pend <= 1'b0;
      r_br_addr <= '0;
    end else begin
      if (r_state == S_FETCH) begin
        if (br_take) begin
          r_br_pend <= 1'b1;
          r_br_addr <= br_target;
        end
      end else if (r_state == S_REDIR) begin
        r_br_pend <= br_take;
        if (br_take) begin
          r_br_addr <= br_target;
        end
      end
    end
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_redir_addr <= '0;
      r_instr      <= '0;
      r_epc        <= '0;
    end else begin
      if (w_redir_load) begin
        r_redir_addr <= w_redir_val;
      end
      if (w_capture) begin
        r_instr <= mem_data;
      end
      if (w_epc_load) begin
        r_epc <= pc_val;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pc_fetch_ctrl
//  Description : Directed self-checking bench for pc_fetch_ctrl, including a
//                behavioural PC register driven by the DUT strobes.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] pc_val;
  logic        pc_inc, pc_ie;
  logic [15:0] pc_in;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [15:0] mem_data;
  logic [15:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic        stall;
  logic        br_take;
  logic [15:0] br_target;
  logic        irq, irq_en, irq_ack;
  logic [15:0] epc;

  int n_chk  = 0;
  int n_fail = 0;
  int n_inc  = 0;
  int n_ie   = 0;
  int n_both = 0;

  pc_fetch_ctrl #(.ADDR_W(16), .IRQ_VEC(16'h0010), .INIT_HOLD(2)) dut (
    .clk(clk), .rst(rst), .pc_val(pc_val), .pc_inc(pc_inc), .pc_ie(pc_ie),
    .pc_in(pc_in), .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .mem_data(mem_data), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .stall(stall), .br_take(br_take),
    .br_target(br_target), .irq(irq), .irq_en(irq_en), .irq_ack(irq_ack),
    .epc(epc)
  );

  always #5 clk = ~clk;

  // PC register model
  always @(posedge clk or posedge rst) begin
    if (rst)         pc_val <= 16'h0000;
    else if (pc_ie)  pc_val <= pc_in;
    else if (pc_inc) pc_val <= pc_val + 16'h0001;
  end

  // Strobe counters
  always @(posedge clk) begin
    if (!rst) begin
      if (pc_inc)          n_inc  = n_inc + 1;
      if (pc_ie)           n_ie   = n_ie + 1;
      if (pc_inc && pc_ie) n_both = n_both + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk = n_chk + 1;
    assert (obs === exp) else begin
      n_fail = n_fail + 1;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".pc_inc"},  32'(pc_inc), 0);
    chk({tag, ".pc_ie"},   32'(pc_ie), 0);
    chk({tag, ".pc_in"},   32'(pc_in), 0);
    chk({tag, ".mem_req"}, 32'(mem_req), 0);
    chk({tag, ".mem_addr"},32'(mem_addr), 0);
    chk({tag, ".instr"},   32'(instr), 0);
    chk({tag, ".valid"},   32'(instr_valid), 0);
    chk({tag, ".irq_ack"}, 32'(irq_ack), 0);
    chk({tag, ".epc"},     32'(epc), 0);
  endtask

  initial begin
    rst = 1'b1; mem_ack = 0; mem_data = 0; instr_ready = 0; stall = 0;
    br_take = 0; br_target = 0; irq = 0; irq_en = 0;
    repeat (3) step();
    chk_all_zero("reset");

    // ---- 1: hold after reset release ----
    rst = 1'b0; settle();
    chk("hold0.mem_req", 32'(mem_req), 0);
    chk("hold0.pc_inc",  32'(pc_inc), 0);
    step();
    chk("hold1.mem_req", 32'(mem_req), 0);
    chk("hold1.pc_ie",   32'(pc_ie), 0);
    step();
    chk("fetch0.mem_req",  32'(mem_req), 1);
    chk("fetch0.mem_addr", 32'(mem_addr), 32'h0000);

    // ---- 2: straight-line zero-wait fetch ----
    instr_ready = 1;
    mem_ack = 1; mem_data = 16'h1111; settle();
    chk("s1.pc_inc", 32'(pc_inc), 1);
    chk("s1.pc_ie",  32'(pc_ie), 0);
    step(); mem_ack = 0; settle();
    chk("s1.valid", 32'(instr_valid), 1);
    chk("s1.instr", 32'(instr), 32'h1111);
    chk("s1.req",   32'(mem_req), 0);
    step();
    chk("s2.valid", 32'(instr_valid), 0);
    chk("s2.addr",  32'(mem_addr), 32'h0001);
    mem_ack = 1; mem_data = 16'h2222;
    step(); mem_ack = 0; settle();
    chk("s2.instr", 32'(instr), 32'h2222);
    step();
    chk("s3.addr", 32'(mem_addr), 32'h0002);
    mem_ack = 1; mem_data = 16'h3333;
    step(); mem_ack = 0; instr_ready = 0; settle();
    chk("s3.instr", 32'(instr), 32'h3333);
    chk("s3.pc",    32'(pc_val), 32'h0003);
    chk("s3.n_inc", 32'(n_inc), 3);

    // ---- 3: decoder back-pressure, stall, memory wait states ----
    for (int i = 0; i < 4; i++) begin
      step();
      chk("bp.valid", 32'(instr_valid), 1);
      chk("bp.instr", 32'(instr), 32'h3333);
    end
    instr_ready = 1; stall = 1;
    step();
    chk("stall.valid", 32'(instr_valid), 1);
    chk("stall.instr", 32'(instr), 32'h3333);
    stall = 0;
    step();
    for (int i = 0; i < 3; i++) begin
      chk("wait.req",    32'(mem_req), 1);
      chk("wait.addr",   32'(mem_addr), 32'h0003);
      chk("wait.pc_inc", 32'(pc_inc), 0);
      step();
      chk("wait.pc",     32'(pc_val), 32'h0003);
    end
    mem_ack = 1; mem_data = 16'h4444; settle();
    chk("w.pc_inc", 32'(pc_inc), 1);
    step(); mem_ack = 0; settle();
    chk("w.instr", 32'(instr), 32'h4444);
    chk("w.n_inc", 32'(n_inc), 4);
    step();

    // ---- 4: branch during FETCH ----
    chk("br.addr", 32'(mem_addr), 32'h0004);
    br_take = 1; br_target = 16'h0040;
    step(); br_take = 0; br_target = 0;
    step();
    mem_ack = 1; mem_data = 16'hDEAD; settle();
    chk("br.pc_inc", 32'(pc_inc), 0);
    step(); mem_ack = 0; settle();
    chk("br.valid", 32'(instr_valid), 0);
    chk("br.pc_ie", 32'(pc_ie), 1);
    chk("br.pc_in", 32'(pc_in), 32'h0040);
    step();
    chk("br.pc_ie_off", 32'(pc_ie), 0);
    chk("br.new_addr",  32'(mem_addr), 32'h0040);
    chk("br.n_inc",     32'(n_inc), 4);
    chk("br.n_ie",      32'(n_ie), 1);

    // ---- 5: interrupt entry at instruction from 0x0005 ----
    instr_ready = 0;
    mem_ack = 1; mem_data = 16'h5555;
    step(); mem_ack = 0;
    br_take = 1; br_target = 16'h0005; settle();
    chk("ibr.valid", 32'(instr_valid), 1);
    step(); br_take = 0; settle();
    chk("ibr.valid_off", 32'(instr_valid), 0);
    chk("ibr.pc_in",     32'(pc_in), 32'h0005);
    step();
    chk("irq.addr", 32'(mem_addr), 32'h0005);
    mem_ack = 1; mem_data = 16'h6666;
    step(); mem_ack = 0;
    irq = 1; irq_en = 1; instr_ready = 1; settle();
    chk("irq.pc",  32'(pc_val), 32'h0006);
    chk("irq.ack", 32'(irq_ack), 1);
    step(); irq = 0; settle();
    chk("irq.ack_off", 32'(irq_ack), 0);
    chk("irq.epc",     32'(epc), 32'h0006);
    chk("irq.pc_ie",   32'(pc_ie), 1);
    chk("irq.pc_in",   32'(pc_in), 32'h0010);
    step();
    chk("irq.vec_addr", 32'(mem_addr), 32'h0010);
    mem_ack = 1; mem_data = 16'h7777;
    step(); mem_ack = 0;
    irq = 1; irq_en = 0; settle();
    chk("noirq.ack", 32'(irq_ack), 0);
    step(); irq = 0; settle();
    chk("noirq.addr", 32'(mem_addr), 32'h0011);
    chk("noirq.epc",  32'(epc), 32'h0006);
    chk("n_ie3",      32'(n_ie), 3);

    // ---- 6: reset mid-fetch, and with a pending branch ----
    chk("rst1.req_before", 32'(mem_req), 1);
    rst = 1; settle();
    chk_all_zero("rst1");
    step();
    rst = 0;
    step(); step();
    chk("rst1.addr", 32'(mem_addr), 32'h0000);
    chk("rst1.req",  32'(mem_req), 1);
    br_take = 1; br_target = 16'h0080;
    step(); br_take = 0; br_target = 0;
    rst = 1; settle();
    chk_all_zero("rst2");
    step();
    rst = 0;
    step(); step();
    chk("rst2.addr", 32'(mem_addr), 32'h0000);
    mem_ack = 1; mem_data = 16'h8888; settle();
    chk("rst2.pc_inc", 32'(pc_inc), 1);
    step(); mem_ack = 0; settle();
    chk("rst2.pc_ie", 32'(pc_ie), 0);
    chk("rst2.instr", 32'(instr), 32'h8888);
    chk("rst2.pc",    32'(pc_val), 32'h0001);
    chk("inc_and_ie", 32'(n_both), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
